// File: rtl/vga_text_buffer.sv
// rtl/vga_text_buffer.sv - 96x32 character/colour frame store with clear and scroll-up engine
// Optional blinking cursor overlay: define VGA_TEXT_CURSOR_EN.
module vga_text_buffer #(
   parameter int COLS     = 96,
   parameter int ROWS     = 32,
   parameter int ADDR_W   = 12,
   parameter int BLANK_CH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wch,
   input  logic [7:0]        wcolor,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd,
   output logic              busy,
   output logic              done,
`ifdef VGA_TEXT_CURSOR_EN
   input  logic              cursor_we,
   input  logic [ADDR_W-1:0] cursor_pos,
`endif
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [7:0]        ch,
   output logic [7:0]        color
);

   localparam int                CELLS   = COLS * ROWS;
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(CELLS - 1);
   localparam logic [ADDR_W-1:0] SC_LAST = ADDR_W'(CELLS - COLS - 1);
   localparam logic [7:0]        BLANK   = 8'(BLANK_CH);

   typedef enum logic [2:0] {S_IDLE, S_CLR, S_SC_RD, S_SC_WR, S_SC_FILL} state_t;

   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_ptr, w_ptr_next;
   logic              r_done, w_done_next;
   logic [7:0]        r_sc_ch, r_sc_col;
   logic [7:0]        r_ch, r_col;
   logic              w_we;
   logic [ADDR_W-1:0] w_wa;
   logic [7:0]        w_wch, w_wcol;

   // Character array holds code XOR BLANK so all-zero power-up contents read as blanks.
   logic [7:0] r_ch_mem  [0:CELLS-1];
   logic [7:0] r_col_mem [0:CELLS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ptr   <= w_ptr_next;
         r_done  <= w_done_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_ptr_next  = r_ptr;
      w_done_next = 1'b0;
      w_we        = 1'b0;
      w_wa        = waddr;
      w_wch       = wch;
      w_wcol      = wcolor;
      case (r_state)
         S_IDLE: begin
            w_we = we && (waddr <= LAST);
            if (cmd_valid && cmd == 2'd0)      w_next = S_CLR;
            else if (cmd_valid && cmd == 2'd1) w_next = S_SC_RD;
         end
         S_CLR, S_SC_FILL: begin
            w_we   = 1'b1;
            w_wa   = r_ptr;
            w_wch  = BLANK;
            w_wcol = 8'd0;
            if (r_ptr == LAST) begin
               w_next      = S_IDLE;
               w_ptr_next  = '0;
               w_done_next = 1'b1;
            end else begin
               w_ptr_next = r_ptr + 1'b1;
            end
         end
         S_SC_RD: w_next = S_SC_WR;
         S_SC_WR: begin
            w_we       = 1'b1;
            w_wa       = r_ptr;
            w_wch      = r_sc_ch;
            w_wcol     = r_sc_col;
            w_ptr_next = r_ptr + 1'b1;
            w_next     = (r_ptr == SC_LAST) ? S_SC_FILL : S_SC_RD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_ch_mem[w_wa]  <= w_wch ^ BLANK;
         r_col_mem[w_wa] <= w_wcol;
      end
      if (r_state == S_SC_RD) begin
         r_sc_ch  <= r_ch_mem[r_ptr + ADDR_W'(COLS)] ^ BLANK;
         r_sc_col <= r_col_mem[r_ptr + ADDR_W'(COLS)];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch  <= BLANK;
         r_col <= 8'd0;
      end else if (vga_addr <= LAST) begin
         r_ch  <= r_ch_mem[vga_addr] ^ BLANK;
         r_col <= r_col_mem[vga_addr];
      end else begin
         r_ch  <= BLANK;
         r_col <= 8'd0;
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;

`ifdef VGA_TEXT_CURSOR_EN
   logic [ADDR_W-1:0] r_cursor, r_vga_addr;
   logic [23:0]       r_blink;
   logic              w_cursor_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cursor   <= '0;
         r_blink    <= '0;
         r_vga_addr <= '0;
      end else begin
         r_blink    <= r_blink + 1'b1;
         r_vga_addr <= vga_addr;
         if (cursor_we) r_cursor <= cursor_pos;
      end
   end

   assign w_cursor_hit = (r_vga_addr == r_cursor) && r_blink[23];
   assign ch           = w_cursor_hit ? 8'd95 : r_ch;
   assign color        = w_cursor_hit ? 8'd0  : r_col;
`else
   assign ch    = r_ch;
   assign color = r_col;
`endif

endmodule

// File: tb/tb_vga_text_buffer.sv
// tb/tb_vga_text_buffer.sv - self-checking bench for vga_text_buffer
module tb_vga_text_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [11:0] waddr;
   logic [7:0]  wch, wcolor;
   logic        cmd_valid;
   logic [1:0]  cmd;
   logic        busy, done;
   logic [11:0] vga_addr;
   logic [7:0]  ch, color;
`ifdef VGA_TEXT_CURSOR_EN
   logic        cursor_we;
   logic [11:0] cursor_pos;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] ch;
      logic [7:0] col;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic        dow;
      logic [11:0] wa;
      logic [7:0]  wc;
      logic [7:0]  wl;
      logic [11:0] ra;
      logic [7:0]  ec;
      logic [7:0]  el;
   } vec_t;
   vec_t vt[8];

   always #5 clk = ~clk;

   vga_text_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .waddr     (waddr),
      .wch       (wch),
      .wcolor    (wcolor),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .busy      (busy),
      .done      (done),
`ifdef VGA_TEXT_CURSOR_EN
      .cursor_we (cursor_we),
      .cursor_pos(cursor_pos),
`endif
      .vga_addr  (vga_addr),
      .ch        (ch),
      .color     (color)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [7:0] c, input logic [7:0] l);
      @(negedge clk);
      we = 1'b1; waddr = a; wch = c; wcolor = l;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic [7:0] ec, input logic [7:0] el);
      exp_t e;
      @(negedge clk);
      vga_addr = a;
      sbq.push_back('{ch: ec, col: el});
      @(negedge clk);
      e = sbq.pop_front();
      chk({name, "_ch"}, int'(ch), int'(e.ch));
      chk({name, "_color"}, int'(color), int'(e.col));
   endtask

   // Called at a negedge; issues the command and watches busy/done for nb+20 cycles.
   task automatic run_cmd(input logic [1:0] c, input int nb, input bit lose_wr, input string name);
      int nbusy = 0, ndone = 0, done_at = -1;
      cmd_valid = 1'b1; cmd = c;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < nb + 20; i++) begin
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (done_at < 0) done_at = i;
         end
         if (lose_wr && i == 10) begin
            we = 1'b1; waddr = 12'd7; wch = 8'd90; wcolor = 8'd3;
         end
         if (lose_wr && i == 11) we = 1'b0;
         @(negedge clk);
      end
      chk({name, "_busy_cycles"}, nbusy, nb);
      chk({name, "_done_pulses"}, ndone, (nb > 0) ? 1 : 0);
      chk({name, "_done_at_busy_fall"}, done_at, (nb > 0) ? nb : -1);
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; wch = '0; wcolor = '0;
      cmd_valid = 1'b0; cmd = '0; vga_addr = '0;
`ifdef VGA_TEXT_CURSOR_EN
      cursor_we = 1'b0; cursor_pos = '0;
`endif
      vt[0] = '{dow: 0, wa: 0,    wc: 0,  wl: 0, ra: 0,    ec: 32, el: 0};
      vt[1] = '{dow: 0, wa: 0,    wc: 0,  wl: 0, ra: 3071, ec: 32, el: 0};
      vt[2] = '{dow: 0, wa: 0,    wc: 0,  wl: 0, ra: 3072, ec: 32, el: 0};
      vt[3] = '{dow: 1, wa: 100,  wc: 65, wl: 2, ra: 100,  ec: 65, el: 2};
      vt[4] = '{dow: 1, wa: 3072, wc: 90, wl: 3, ra: 0,    ec: 32, el: 0};
      vt[5] = '{dow: 0, wa: 0,    wc: 0,  wl: 0, ra: 3072, ec: 32, el: 0};
      vt[6] = '{dow: 1, wa: 4095, wc: 1,  wl: 1, ra: 4095, ec: 32, el: 0};
      vt[7] = '{dow: 1, wa: 3070, wc: 66, wl: 6, ra: 3070, ec: 66, el: 6};

      repeat (2) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_ch", int'(ch), 32);
      chk("reset_color", int'(color), 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (vt[i].dow) wr(vt[i].wa, vt[i].wc, vt[i].wl);
         rd($sformatf("vec%0d", i), vt[i].ra, vt[i].ec, vt[i].el);
      end
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);

      // Same-edge write and read of one cell returns the old contents.
      @(negedge clk);
      we = 1'b1; waddr = 12'd200; wch = 8'd1; wcolor = 8'd5; vga_addr = 12'd200;
      @(negedge clk);
      we = 1'b0;
      chk("rw_same_cell_old_ch", int'(ch), 32);
      rd("rw_same_cell_new", 12'd200, 8'd1, 8'd5);

      wr(12'd5, 8'd65, 8'd1);
      run_cmd(2'd0, 3072, 1'b1, "clear");
      rd("clear_cell5", 12'd5, 8'd32, 8'd0);
      rd("clear_cell7_lost_wr", 12'd7, 8'd32, 8'd0);
      rd("clear_cell100", 12'd100, 8'd32, 8'd0);

      wr(12'd99, 8'd66, 8'd4);
      wr(12'd3071, 8'd67, 8'd5);
      wr(12'd3, 8'd81, 8'd2);
      run_cmd(2'd1, 6048, 1'b0, "scroll");
      rd("scroll_cell3", 12'd3, 8'd66, 8'd4);
      rd("scroll_cell99", 12'd99, 8'd32, 8'd0);
      rd("scroll_cell2975", 12'd2975, 8'd67, 8'd5);
      rd("scroll_cell2976", 12'd2976, 8'd32, 8'd0);
      rd("scroll_cell3071", 12'd3071, 8'd32, 8'd0);

      // Abort a scroll with reset, then start a clear right after release.
      @(negedge clk);
      cmd_valid = 1'b1; cmd = 2'd1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (1000) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      run_cmd(2'd0, 3072, 1'b0, "post_reset_clear");

      run_cmd(2'd2, 0, 1'b0, "reserved2");
      run_cmd(2'd3, 0, 1'b0, "reserved3");

`ifdef VGA_TEXT_CURSOR_EN
      wr(12'd10, 8'd88, 8'd0);
      @(negedge clk);
      cursor_we = 1'b1; cursor_pos = 12'd10;
      @(negedge clk);
      cursor_we = 1'b0;
      rd("cursor_phase0", 12'd10, 8'd88, 8'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
